load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the RISC-V datapath.
- Takes the ALU result as the effective address and performs one load or store per request to a data memory with variable latency, using a req/ready handshake.
- Stalls the pipeline while the access is outstanding.
- Returns sign/zero-extended load data and flags misaligned, illegal-width and timed-out accesses.

Parameters:
- n, 32, datapath/address width; must be 32 (4 byte lanes).
- TIMEOUT, 255, maximum ACCESS-state cycles waiting for mem_ready before a fault; 8-bit counter, legal 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  EX stage presents a memory instruction.
- req_load  input  1  request is a load.
- req_store  input  1  request is a store; req_load=req_store=1 is treated as illegal.
- funct3  input  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
- addr  input  n  effective address (ALU output).
- store_data  input  n  rs2 value for stores.
- stall  output  1  holds the pipeline (combinational).
- done  output  1  one-cycle pulse: access complete.
- load_data  output  n  formatted load result; valid while done=1.
- fault  output  1  one-cycle pulse: misaligned, illegal or timeout.
- fault_cause  output  2  01 misaligned, 10 illegal, 11 timeout; valid while fault=1.
- mem_req  output  1  memory request.
- mem_we  output  1  write enable.
- mem_addr  output  n  word address, bits [1:0] forced to 00.
- mem_be  output  4  byte enables.
- mem_wdata  output  n  lane-replicated store data.
- mem_ready  input  1  memory accepted a write, or returned mem_rdata.
- mem_rdata  input  n  read data, sampled on the edge where mem_ready=1.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all registered outputs 0 (done, load_data, fault, fault_cause, mem_req, mem_we, mem_addr, mem_be, mem_wdata); timeout counter 0. Reset mid-access drops mem_req immediately and discards the access.
- States: IDLE, ACCESS, DONE, FAULT.
- A request is active when req_valid & (req_load | req_store).
- IDLE, request active:
  - Illegal (both load and store set, store funct3 not in 000/001/010, or load funct3 in 011/110/111) -> FAULT, cause 10.
  - Misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=00) -> FAULT, cause 01.
  - Otherwise: register addr, width, sign, we, be and wdata; go to ACCESS.
- IDLE, no request active: stay in IDLE.
- ACCESS:
  - mem_req=1; mem_addr, mem_we, mem_be and mem_wdata held stable.
  - Counter increments each cycle.
  - mem_ready=1 -> DONE; load_data registered from mem_rdata on the same edge.
  - Counter reaches TIMEOUT without mem_ready -> FAULT, cause 11; mem_req drops on entry.
- DONE: done=1 for one cycle, then IDLE. For stores, load_data=0.
- FAULT: fault=1 for one cycle, then IDLE. No memory transaction is issued for misaligned or illegal requests.
- stall = (IDLE & request active) | ACCESS. stall=0 in DONE and FAULT, so the pipeline advances on the completion cycle; the next cycle's req_valid belongs to the next instruction.
- Minimum latency: request cycle 0, mem_req cycle 1, mem_ready sampled cycle 1, done cycle 2.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << {addr[1],1'b0}.
  - W: 1111.
- Store data: SB = {4{store_data[7:0]}}; SH = {2{store_data[15:0]}}; SW = store_data.
- Load formatting: select lane by addr[1:0] (byte) or addr[1] (half). B/H sign-extend; BU/HU zero-extend; W passes through.
- mem_ready while not in ACCESS is ignored.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, mem_ready high in cycle 1 -> mem_addr=0x100, mem_be=1111, done in cycle 2, load_data=0xDEADBEEF, stall high in cycles 0-1.
- LB/LBU addr=0x103, mem_rdata=0x80112233 -> LB load_data=0xFFFFFF80; LBU load_data=0x00000080; mem_be=1000.
- SH addr=0x202, store_data=0x0000ABCD, mem_ready delayed 5 cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD held stable 5 cycles, then done.
- LW addr=0x101 -> no mem_req, fault=1 with cause 01 in cycle 1; funct3=011 load -> fault cause 10.
- TIMEOUT=4, mem_ready held 0 -> mem_req for 4 cycles, then fault cause 11, mem_req=0, return to IDLE.
- rst_n pulsed low during ACCESS -> mem_req=0 asynchronously, all outputs 0, IDLE; next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V memory-access stage: one load/store per request, variable-latency memory
// Checks alignment and legality up front, then holds a single memory access until mem_ready or timeout.
module load_store_unit #(
   parameter int n       = 32,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   input  logic         req_load,
   input  logic         req_store,
   input  logic [2:0]   funct3,
   input  logic [n-1:0] addr,
   input  logic [n-1:0] store_data,
   output logic         stall,
   output logic         done,
   output logic [n-1:0] load_data,
   output logic         fault,
   output logic [1:0]   fault_cause,
   output logic         mem_req,
   output logic         mem_we,
   output logic [n-1:0] mem_addr,
   output logic [3:0]   mem_be,
   output logic [n-1:0] mem_wdata,
   input  logic         mem_ready,
   input  logic [n-1:0] mem_rdata
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE, ST_FAULT} state_t;

   localparam logic [7:0] TO = 8'(TIMEOUT);

   state_t       state, state_nxt;
   logic [7:0]   cnt;
   logic [7:0]   cnt_inc;
   logic [2:0]   f3_q;
   logic [1:0]   lane_q;
   logic [1:0]   cause_nxt;
   logic         issue;
   logic         active;
   logic         illegal;
   logic         misaligned;
   logic [3:0]   be_c;
   logic [n-1:0] wdata_c;
   logic [n-1:0] rsh;
   logic [15:0]  half;
   logic [n-1:0] fmt;

   assign active  = req_valid & (req_load | req_store);
   assign cnt_inc = cnt + 8'd1;

   // Stores only allow B/H/W; loads additionally allow BU/HU.
   assign illegal = (req_load & req_store) |
                    (req_store ? (funct3[2] | (funct3[1:0] == 2'b11))
                               : ((funct3[1:0] == 2'b11) | (funct3 == 3'b110)));
   assign misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                       ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = store_data;
      case (funct3[1:0])
         2'b00: begin
            be_c    = 4'b0001 << addr[1:0];
            wdata_c = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_c    = 4'b0011 << {addr[1], 1'b0};
            wdata_c = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      rsh  = mem_rdata >> {lane_q, 3'b000};
      half = lane_q[1] ? mem_rdata[n-1:n/2] : mem_rdata[n/2-1:0];
      case (f3_q)
         3'b000:  fmt = {{(n-8){rsh[7]}}, rsh[7:0]};
         3'b001:  fmt = {{(n-16){half[15]}}, half};
         3'b100:  fmt = {{(n-8){1'b0}}, rsh[7:0]};
         3'b101:  fmt = {{(n-16){1'b0}}, half};
         default: fmt = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cause_nxt = 2'b00;
      issue     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (active) begin
               if (illegal) begin
                  state_nxt = ST_FAULT;
                  cause_nxt = 2'b10;
               end else if (misaligned) begin
                  state_nxt = ST_FAULT;
                  cause_nxt = 2'b01;
               end else begin
                  state_nxt = ST_ACCESS;
                  issue     = 1'b1;
               end
            end
         end
         ST_ACCESS: begin
            // A response on the last permitted cycle still wins over the timeout.
            if (mem_ready) begin
               state_nxt = ST_DONE;
            end else if (cnt_inc == TO) begin
               state_nxt = ST_FAULT;
               cause_nxt = 2'b11;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign stall = ((state == ST_IDLE) & active) | (state == ST_ACCESS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done        <= 1'b0;
         load_data   <= '0;
         fault       <= 1'b0;
         fault_cause <= 2'b00;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_be      <= 4'b0000;
         mem_wdata   <= '0;
         cnt         <= 8'd0;
         f3_q        <= 3'b000;
         lane_q      <= 2'b00;
      end else begin
         done        <= (state == ST_ACCESS) & mem_ready;
         fault       <= (state_nxt == ST_FAULT);
         fault_cause <= cause_nxt;
         if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= req_store;
            mem_addr  <= {addr[n-1:2], 2'b00};
            mem_be    <= be_c;
            mem_wdata <= wdata_c;
            f3_q      <= funct3;
            lane_q    <= addr[1:0];
            cnt       <= 8'd0;
         end else if (state == ST_ACCESS) begin
            cnt <= cnt_inc;
            if (state_nxt != ST_ACCESS) mem_req <= 1'b0;
            if (mem_ready) load_data <= mem_we ? '0 : fmt;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit: directed table, random vs model, timeout, reset
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_valid_t4 = 1'b0;
   logic        req_load = 1'b0, req_store = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0, store_data = '0;
   logic        mem_ready = 1'b0, mem_ready_t4 = 1'b0;
   logic [31:0] mem_rdata = '0;

   logic        stall, done, fault, mem_req, mem_we;
   logic [31:0] load_data, mem_addr, mem_wdata;
   logic [1:0]  fault_cause;
   logic [3:0]  mem_be;

   logic        stall_t4, done_t4, fault_t4, mem_req_t4, mem_we_t4;
   logic [31:0] load_data_t4, mem_addr_t4, mem_wdata_t4;
   logic [1:0]  fault_cause_t4;
   logic [3:0]  mem_be_t4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   load_store_unit #(.n(32), .TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
      .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall), .done(done),
      .load_data(load_data), .fault(fault), .fault_cause(fault_cause), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   load_store_unit #(.n(32), .TIMEOUT(4)) dut_t4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_t4), .req_load(req_load), .req_store(req_store),
      .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall_t4), .done(done_t4),
      .load_data(load_data_t4), .fault(fault_t4), .fault_cause(fault_cause_t4), .mem_req(mem_req_t4),
      .mem_we(mem_we_t4), .mem_addr(mem_addr_t4), .mem_be(mem_be_t4), .mem_wdata(mem_wdata_t4),
      .mem_ready(mem_ready_t4), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] sd;
      logic [31:0] rd;
      int          lat;
      logic [1:0]  cause;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] ldata;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: byte-lane arithmetic straight from the access rules.
   function automatic vec_t model(input logic ld, input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] sd,
                                  input logic [31:0] rd, input int lat);
      vec_t   m;
      int     size, off;
      longint v;
      logic   bad;
      m.ld = ld; m.st = st; m.f3 = f3; m.a = a; m.sd = sd; m.rd = rd; m.lat = lat;
      m.be = 4'b0000; m.wd = '0; m.ldata = '0;
      size = 1 << f3[1:0];
      off  = int'(a % 4);
      bad  = (ld && st) || (st && f3 > 3'd2) || (ld && (f3 == 3'd3 || f3 > 3'd5));
      if (bad)                   m.cause = 2'b10;
      else if (off % size != 0)  m.cause = 2'b01;
      else                       m.cause = 2'b00;
      if (m.cause == 2'b00) begin
         for (int i = 0; i < 4; i++) begin
            m.be[i] = (i >= off) && (i < off + size);
            m.wd[8*i +: 8] = sd[8*(i % size) +: 8];
         end
         if (!st) begin
            v = 0;
            for (int j = 0; j < size; j++) v += longint'(rd[8*(off+j) +: 8]) << (8*j);
            if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size-1))) v -= longint'(1) << (8*size);
            m.ldata = v[31:0];
         end
      end
      return m;
   endfunction

   task automatic run_txn(input vec_t v);
      step();
      req_valid = 1'b1; req_load = v.ld; req_store = v.st; funct3 = v.f3;
      addr = v.a; store_data = v.sd;
      mem_ready = 1'(int'($urandom_range(0, 1)));
      mem_rdata = $urandom;
      #1;
      chk("stall_req", {31'd0, stall}, 32'd1);
      chk("mem_req_idle", {31'd0, mem_req}, 32'd0);
      chk("done_idle", {31'd0, done}, 32'd0);
      chk("fault_idle", {31'd0, fault}, 32'd0);
      if (v.cause != 2'b00) begin
         step();
         req_valid = 1'b0;
         mem_ready = 1'(int'($urandom_range(0, 1)));
         #1;
         chk("fault", {31'd0, fault}, 32'd1);
         chk("fault_cause", {30'd0, fault_cause}, {30'd0, v.cause});
         chk("mem_req_fault", {31'd0, mem_req}, 32'd0);
         chk("stall_fault", {31'd0, stall}, 32'd0);
         chk("done_fault", {31'd0, done}, 32'd0);
      end else begin
         for (int k = 1; k <= v.lat; k++) begin
            step();
            mem_ready = (k == v.lat);
            mem_rdata = (k == v.lat) ? v.rd : $urandom;
            #1;
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("mem_addr", mem_addr, {v.a[31:2], 2'b00});
            chk("mem_we", {31'd0, mem_we}, {31'd0, v.st});
            chk("mem_be", {28'd0, mem_be}, {28'd0, v.be});
            if (v.st) chk("mem_wdata", mem_wdata, v.wd);
            chk("stall_access", {31'd0, stall}, 32'd1);
            chk("done_early", {31'd0, done}, 32'd0);
         end
         step();
         req_valid = 1'b0; mem_ready = 1'b0;
         #1;
         chk("done", {31'd0, done}, 32'd1);
         chk("load_data", load_data, v.ldata);
         chk("stall_done", {31'd0, stall}, 32'd0);
         chk("fault_done", {31'd0, fault}, 32'd0);
      end
   endtask

   vec_t tbl[15];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //             ld    st    f3      addr          sd            rdata       lat cause  be       wdata         load_data
      tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 2'b00, 4'b1111, 32'h0,        32'hDEAD_BEEF};
      tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8011_2233, 1, 2'b00, 4'b1000, 32'h0,        32'hFFFF_FF80};
      tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8011_2233, 1, 2'b00, 4'b1000, 32'h0,        32'h0000_0080};
      tbl[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h1111_1111, 5, 2'b00, 4'b1100, 32'hABCD_ABCD, 32'h0};
      tbl[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         1, 2'b01, 4'b0000, 32'h0,        32'h0};
      tbl[5]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         1, 2'b10, 4'b0000, 32'h0,        32'h0};
      tbl[6]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 2, 2'b00, 4'b1100, 32'h0,        32'hFFFF_8001};
      tbl[7]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h1234_F00D, 1, 2'b00, 4'b0011, 32'h0,        32'h0000_F00D};
      tbl[8]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0,         3, 2'b00, 4'b0010, 32'hA5A5_A5A5, 32'h0};
      tbl[9]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h1234_5678, 32'h0,         1, 2'b00, 4'b1111, 32'h1234_5678, 32'h0};
      tbl[10] = '{1'b0, 1'b1, 3'b100, 32'h0000_0400, 32'h0,        32'h0,         1, 2'b10, 4'b0000, 32'h0,        32'h0};
      tbl[11] = '{1'b1, 1'b1, 3'b010, 32'h0000_0400, 32'h0,        32'h0,         1, 2'b10, 4'b0000, 32'h0,        32'h0};
      tbl[12] = '{1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0,        32'h0,         1, 2'b01, 4'b0000, 32'h0,        32'h0};
      tbl[13] = '{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,         1, 2'b01, 4'b0000, 32'h0,        32'h0};
      tbl[14] = '{1'b1, 1'b0, 3'b111, 32'h0000_0103, 32'h0,        32'h0,         1, 2'b10, 4'b0000, 32'h0,        32'h0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) run_txn(tbl[i]);

      // Timeout on the TIMEOUT=4 instance
      step();
      req_valid_t4 = 1'b1; req_load = 1'b1; req_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
      #1;
      chk("t4_stall_req", {31'd0, stall_t4}, 32'd1);
      for (int k = 1; k <= 4; k++) begin
         step();
         #1;
         chk("t4_mem_req", {31'd0, mem_req_t4}, 32'd1);
         chk("t4_fault_early", {31'd0, fault_t4}, 32'd0);
      end
      step();
      req_valid_t4 = 1'b0;
      #1;
      chk("t4_fault", {31'd0, fault_t4}, 32'd1);
      chk("t4_cause", {30'd0, fault_cause_t4}, 32'd3);
      chk("t4_mem_req_off", {31'd0, mem_req_t4}, 32'd0);
      chk("t4_stall_fault", {31'd0, stall_t4}, 32'd0);
      step();
      #1;
      chk("t4_fault_clear", {31'd0, fault_t4}, 32'd0);
      chk("t4_idle_mem_req", {31'd0, mem_req_t4}, 32'd0);

      // Asynchronous reset during ACCESS
      step();
      req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; funct3 = 3'b010; addr = 32'h500;
      mem_ready = 1'b0;
      step();
      #1;
      chk("ar_mem_req_before", {31'd0, mem_req}, 32'd1);
      req_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_mem_req", {31'd0, mem_req}, 32'd0);
      chk("ar_mem_addr", mem_addr, 32'd0);
      chk("ar_mem_be", {28'd0, mem_be}, 32'd0);
      chk("ar_mem_we", {31'd0, mem_we}, 32'd0);
      chk("ar_done", {31'd0, done}, 32'd0);
      chk("ar_stall", {31'd0, stall}, 32'd0);
      #1;
      rst_n = 1'b1;
      run_txn(model(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, 2));

      // Randomized requests against the reference model
      for (int r = 0; r < 200; r++) begin
         int   kind;
         logic ld, st;
         kind = int'($urandom_range(0, 9));
         ld = (kind <= 5);
         st = (kind == 0) || (kind > 5);
         run_txn(model(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                       int'($urandom_range(1, 6))));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
